// File: rtl/y86_decode_regfile.sv
// rtl/y86_decode_regfile.sv - Y86-64 decode-side register file with writeback ports.
// Optional macro WB_BYPASS_EN: same-edge write data is forwarded to valA/valB.
module y86_decode_regfile #(
  parameter int unsigned          DATA_W    = 64,
  parameter logic [DATA_W-1:0]    RSP_RESET = 64'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_rA,
  input  logic [3:0]        d_rB,
  input  logic              w_en,
  input  logic [3:0]        w_icode,
  input  logic [3:0]        w_rA,
  input  logic [3:0]        w_rB,
  input  logic              w_cnd,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [DATA_W-1:0] w_valM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [3:0]        srcA_q,
  output logic [3:0]        srcB_q,
  output logic              out_valid,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val
);

  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] R_RSP  = 4'h4;

  // Entry 15 is the "none" slot: held at zero so every index reads safely.
  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];

  logic [DATA_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
  logic [3:0]        src_a_q, src_a_d, src_b_q, src_b_d;
  logic              out_valid_q, out_valid_d;

  logic [3:0] src_a, src_b, dst_e, dst_m;

  always_comb begin
    src_a = R_NONE;
    case (d_icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = d_rA;
      4'h9, 4'hB:             src_a = R_RSP;
      default:                src_a = R_NONE;
    endcase

    src_b = R_NONE;
    case (d_icode)
      4'h4, 4'h5, 4'h6:       src_b = d_rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = R_RSP;
      default:                src_b = R_NONE;
    endcase

    dst_e = R_NONE;
    case (w_icode)
      4'h2:                   dst_e = w_cnd ? w_rB : R_NONE;
      4'h3, 4'h6:             dst_e = w_rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = R_RSP;
      default:                dst_e = R_NONE;
    endcase

    dst_m = R_NONE;
    case (w_icode)
      4'h5, 4'hB: dst_m = w_rA;
      default:    dst_m = R_NONE;
    endcase
  end

  // M is applied after E so popq %rsp leaves the loaded value in %rsp.
  always_comb begin
    for (int i = 0; i < 16; i++) regs_d[i] = regs_q[i];
    if (w_en) begin
      if (dst_e != R_NONE) regs_d[dst_e] = w_valE;
      if (dst_m != R_NONE) regs_d[dst_m] = w_valM;
    end
    regs_d[15] = '0;
  end

  always_comb begin
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    out_valid_d = d_valid;
    if (d_valid) begin
      src_a_d = src_a;
      src_b_d = src_b;
`ifdef WB_BYPASS_EN
      val_a_d = regs_d[src_a];
      val_b_d = regs_d[src_b];
`else
      val_a_d = regs_q[src_a];
      val_b_d = regs_q[src_b];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= (i == 4) ? RSP_RESET : '0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      src_a_q     <= R_NONE;
      src_b_q     <= R_NONE;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign valA      = val_a_q;
  assign valB      = val_b_q;
  assign srcA_q    = src_a_q;
  assign srcB_q    = src_b_q;
  assign out_valid = out_valid_q;
  assign dbg_val   = regs_q[dbg_sel];

endmodule

// File: tb/tb_y86_decode_regfile.sv
// tb/tb_y86_decode_regfile.sv - Directed vector bench for y86_decode_regfile.
// Honours WB_BYPASS_EN for the same-edge read/write expectations.
module tb_y86_decode_regfile;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, d_valid, w_en, w_cnd, out_valid;
  logic [3:0]  d_icode, d_rA, d_rB, w_icode, w_rA, w_rB, dbg_sel, srcA_q, srcB_q;
  logic [63:0] w_valE, w_valM, valA, valB, dbg_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y86_decode_regfile #(.DATA_W(64), .RSP_RESET(64'h100)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_icode(d_icode), .d_rA(d_rA), .d_rB(d_rB),
    .w_en(w_en), .w_icode(w_icode), .w_rA(w_rA), .w_rB(w_rB), .w_cnd(w_cnd),
    .w_valE(w_valE), .w_valM(w_valM), .valA(valA), .valB(valB), .srcA_q(srcA_q),
    .srcB_q(srcB_q), .out_valid(out_valid), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  typedef struct packed {
    logic        rst, dv;
    logic [3:0]  dic, dra, drb;
    logic        we;
    logic [3:0]  wic, wra, wrb;
    logic        wc;
    logic [63:0] wve, wvm;
    logic [3:0]  dsel;
    logic [63:0] eva, evb;
    logic [3:0]  esa, esb;
    logic        eov;
    logic [63:0] edbg;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic r, logic dv, logic [3:0] dic, logic [3:0] dra, logic [3:0] drb,
                              logic we, logic [3:0] wic, logic [3:0] wra, logic [3:0] wrb, logic wc,
                              logic [63:0] wve, logic [63:0] wvm, logic [3:0] dsel,
                              logic [63:0] eva, logic [63:0] evb, logic [3:0] esa, logic [3:0] esb,
                              logic eov, logic [63:0] edbg);
    vec_t v;
    v.rst = r; v.dv = dv; v.dic = dic; v.dra = dra; v.drb = drb;
    v.we = we; v.wic = wic; v.wra = wra; v.wrb = wrb; v.wc = wc;
    v.wve = wve; v.wvm = wvm; v.dsel = dsel;
    v.eva = eva; v.evb = evb; v.esa = esa; v.esb = esb; v.eov = eov; v.edbg = edbg;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; d_valid = v.dv; d_icode = v.dic; d_rA = v.dra; d_rB = v.drb;
    w_en = v.we; w_icode = v.wic; w_rA = v.wra; w_rB = v.wrb; w_cnd = v.wc;
    w_valE = v.wve; w_valM = v.wvm; dbg_sel = v.dsel;
    @(posedge clk);
    #1;
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check(input int idx, input vec_t v);
    chk64($sformatf("v%0d valA", idx), valA, v.eva);
    chk64($sformatf("v%0d valB", idx), valB, v.evb);
    chk64($sformatf("v%0d srcA_q", idx), {60'd0, srcA_q}, {60'd0, v.esa});
    chk64($sformatf("v%0d srcB_q", idx), {60'd0, srcB_q}, {60'd0, v.esb});
    chk64($sformatf("v%0d out_valid", idx), {63'd0, out_valid}, {63'd0, v.eov});
    chk64($sformatf("v%0d dbg_val", idx), dbg_val, v.edbg);
  endtask

  initial begin
    vec_t v;
    //          rst dv dic   dra   drb   we wic   wra   wrb   wc wvE     wvM    dsel  eva                     evb      esa   esb   eov edbg
    vecs[0]  = mk(1, 0, 4'h0, 4'hF, 4'hF, 0, 4'h0, 4'hF, 4'hF, 0, 0,      0,     4'h4, 0,                      0,       4'hF, 4'hF, 0, 64'h100);
    vecs[1]  = mk(0, 0, 4'h0, 4'hF, 4'hF, 0, 4'h0, 4'hF, 4'hF, 0, 0,      0,     4'h3, 0,                      0,       4'hF, 4'hF, 0, 0);
    vecs[2]  = mk(0, 0, 4'h0, 4'hF, 4'hF, 1, 4'h3, 4'hF, 4'h3, 0, 216,    0,     4'h3, 0,                      0,       4'hF, 4'hF, 0, 216);
    vecs[3]  = mk(0, 1, 4'h6, 4'h3, 4'h3, 0, 4'h0, 4'hF, 4'hF, 0, 0,      0,     4'h3, 216,                    216,     4'h3, 4'h3, 1, 216);
    vecs[4]  = mk(0, 0, 4'h0, 4'hF, 4'hF, 1, 4'h2, 4'hF, 4'h2, 0, 512,    0,     4'h2, 216,                    216,     4'h3, 4'h3, 0, 0);
    vecs[5]  = mk(0, 0, 4'h0, 4'hF, 4'hF, 1, 4'h2, 4'hF, 4'h2, 1, 512,    0,     4'h2, 216,                    216,     4'h3, 4'h3, 0, 512);
    vecs[6]  = mk(0, 0, 4'h0, 4'hF, 4'hF, 1, 4'hB, 4'h4, 4'hF, 0, 64'h108, 64'h55, 4'h4, 216,                  216,     4'h3, 4'h3, 0, 64'h55);
    vecs[7]  = mk(0, 1, 4'h2, 4'h5, 4'hF, 1, 4'h3, 4'hF, 4'h5, 0, 7,      0,     4'h5, BYP ? 64'd7 : 64'd0,    0,       4'h5, 4'hF, 1, 7);
    vecs[8]  = mk(0, 1, 4'hA, 4'h2, 4'hF, 0, 4'h0, 4'hF, 4'hF, 0, 0,      0,     4'hF, 512,                    64'h55,  4'h2, 4'h4, 1, 0);
    vecs[9]  = mk(0, 1, 4'h9, 4'hF, 4'hF, 1, 4'h8, 4'hF, 4'hF, 0, 64'h200, 0,    4'h4, BYP ? 64'h200 : 64'h55, BYP ? 64'h200 : 64'h55, 4'h4, 4'h4, 1, 64'h200);
    vecs[10] = mk(0, 1, 4'hC, 4'h1, 4'h1, 1, 4'hD, 4'h1, 4'h1, 1, 99,     88,    4'h1, 0,                      0,       4'hF, 4'hF, 1, 0);
    vecs[11] = mk(0, 0, 4'h0, 4'hF, 4'hF, 1, 4'h5, 4'h6, 4'hF, 0, 64'h33, 64'h77, 4'h6, 0,                     0,       4'hF, 4'hF, 0, 64'h77);
    vecs[12] = mk(0, 1, 4'h4, 4'h6, 4'h3, 1, 4'h6, 4'hF, 4'h7, 0, 64'h11, 0,     4'h7, 64'h77,                 216,     4'h6, 4'h3, 1, 64'h11);
    vecs[13] = mk(1, 1, 4'h2, 4'h6, 4'hF, 1, 4'h3, 4'hF, 4'h1, 0, 9,      0,     4'h1, 0,                      0,       4'hF, 4'hF, 0, 0);
    vecs[14] = mk(0, 0, 4'h0, 4'hF, 4'hF, 0, 4'h0, 4'hF, 4'hF, 0, 0,      0,     4'h4, 0,                      0,       4'hF, 4'hF, 0, 64'h100);

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      check(i, vecs[i]);
    end

    // popq %rsp read on the same edge: both reads see %rsp, M wins under forwarding.
    v = mk(0, 1, 4'hB, 4'hF, 4'hF, 1, 4'hB, 4'h4, 4'hF, 0, 64'h1, 64'h2, 4'h4,
           BYP ? 64'h2 : 64'h100, BYP ? 64'h2 : 64'h100, 4'h4, 4'h4, 1, 64'h2);
    apply(v);
    check(100, v);

    // Decode outputs hold across idle cycles while out_valid drops.
    v = mk(0, 0, 4'h6, 4'h1, 4'h1, 0, 4'h0, 4'hF, 4'hF, 0, 0, 0, 4'h4,
           BYP ? 64'h2 : 64'h100, BYP ? 64'h2 : 64'h100, 4'h4, 4'h4, 0, 64'h2);
    for (int k = 0; k < 3; k++) begin
      apply(v);
      check(101 + k, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_decode_regfile.md
Name: y86_decode_regfile

Overview:
- Read-side counterpart to the sequential writeback stage: a 15-entry Y86-64 register file with integrated decode logic.
- The decode side derives srcA/srcB from icode/rA/rB and returns valA/valB registered one cycle later.
- The writeback side derives dstE/dstM from its own icode/rA/rB/cnd and commits valE/valM on the clock edge.
- Sits between fetch and execute; the writeback stage drives its write ports.

Parameters:
- DATA_W, 64, register and data width in bits.
- RSP_RESET, 64'd0, reset value of %rsp (reg 4); all other registers reset to 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- d_valid  input  1  decode request strobe; sampled on rising edge.
- d_icode  input  4  instruction code of instruction being decoded.
- d_rA  input  4  rA field (4'hF = none).
- d_rB  input  4  rB field (4'hF = none).
- w_en  input  1  writeback commit strobe.
- w_icode  input  4  icode of instruction in writeback.
- w_rA  input  4  rA field of writeback instruction.
- w_rB  input  4  rB field of writeback instruction.
- w_cnd  input  1  condition result (gates cmovXX).
- w_valE  input  DATA_W  ALU result.
- w_valM  input  DATA_W  memory read result.
- valA  output  DATA_W  registered read of srcA (0 if srcA = F).
- valB  output  DATA_W  registered read of srcB (0 if srcB = F).
- srcA_q  output  4  registered srcA used for valA.
- srcB_q  output  4  registered srcB used for valB.
- out_valid  output  1  valA/valB/srcX_q valid; d_valid delayed one cycle.
- dbg_sel  input  4  debug read index.
- dbg_val  output  DATA_W  combinational read of reg[dbg_sel]; 0 for 4'hF.

Behaviour:
- Storage: regs 0..14, DATA_W each. Index 15 is "none"; it is never written and always reads 0.
- srcA decode:
  - rA for icode 2, 4, 6, A.
  - 4 (%rsp) for 9, B.
  - F otherwise.
- srcB decode:
  - rB for 4, 5, 6.
  - 4 for 8, 9, A, B.
  - F otherwise.
- dstE decode:
  - rB for 2 only when w_cnd=1; for 3 and 6.
  - 4 for 8, 9, A, B.
  - F otherwise. cmovXX with w_cnd=0 gives F.
- dstM decode: w_rA for 5 and B; F otherwise.
- Undefined icodes (C-F): all src/dst = F, so no write and reads return 0.
- Write: on a rising edge with w_en=1 and rst=0:
  - reg[dstE] <= w_valE if dstE != F.
  - reg[dstM] <= w_valM if dstM != F.
  - If dstE == dstM != F (popq %rsp), valM wins.
- Read: on a rising edge with d_valid=1, valA/valB/srcA_q/srcB_q load from register contents before that edge's write, i.e. old values. Latency is 1 cycle.
- out_valid <= d_valid every edge.
- When d_valid=0, valA/valB/srcX_q hold their previous values.
- Reset (rst=1 at an edge), overriding all same-edge writes and reads:
  - Every register is cleared, except reg 4 which loads RSP_RESET.
  - valA, valB = 0; srcA_q, srcB_q = 4'hF; out_valid = 0.
- Reset mid-operation: any write pending on that edge is discarded.
- Simultaneous read and write of the same register: reads old value unless WB_BYPASS_EN is defined (see Optional Feature).
- No X propagation: every output is defined after the first reset edge.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: on a simultaneous read and write, valA/valB take the value being written on that same edge, following the same M-over-E priority.
  - Example: srcA == dstM with w_en=1 gives valA = w_valM.
  - This gives same-cycle write-through for pipelined use.
- Undefined: reads always return pre-edge contents.

Test Plan:
1. Reset with RSP_RESET=64'h100 → dbg_val(4) = 64'h100, dbg_val(3) = 0, out_valid = 0, srcA_q = F.
2. w_en, w_icode=3, w_rB=3, w_valE=216; next edge d_icode=6, d_rA=3, d_rB=3 → after 1 cycle valA = valB = 216, out_valid = 1.
3. w_icode=2, w_cnd=0, w_rB=2, w_valE=512 → reg2 unchanged (0); repeat with w_cnd=1 → reg2 = 512.
4. w_icode=B, w_rA=4, w_valE=64'h108, w_valM=64'h55 → reg4 = 64'h55 (M wins).
5. Same edge: w_icode=3, w_rB=5, w_valE=7, and d_icode=2, d_rA=5 → valA = 0 without WB_BYPASS_EN, 7 with it; reg5 = 7 in both.
6. rst asserted on the same edge as w_en, w_icode=3, w_rB=1, w_valE=9 → reg1 = 0, valA = 0, out_valid = 0.
